// File: rtl/rans_enc_ctrl.sv
// Sequencer for one rANS encoder core: loads and normalisation-checks the frequency table,
// feeds the symbol stream under encoder flow control, forwards output bytes and reports status.
module rans_enc_ctrl #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    tbl_valid_i,
  input  logic [RESOLUTION-1:0]   tbl_freq_i,
  output logic                    tbl_ready_o,
  input  logic                    sym_valid_i,
  input  logic [SYMBOL_WIDTH-1:0] sym_i,
  input  logic                    sym_last_i,
  output logic                    sym_ready_o,
  output logic                    enc_rst_o,
  output logic                    enc_en_o,
  output logic                    enc_freq_wr_o,
  output logic [RESOLUTION-1:0]   enc_freq_o,
  output logic [RESOLUTION-1:0]   enc_cum_freq_o,
  output logic [SYMBOL_WIDTH-1:0] enc_symb_o,
  input  logic                    enc_ready_i,
  input  logic                    enc_valid_i,
  input  logic [SYMBOL_WIDTH-1:0] enc_data_i,
  output logic                    out_valid_o,
  output logic [SYMBOL_WIDTH-1:0] out_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [CNT_WIDTH-1:0]    byte_cnt_o
);

  localparam int ACC_WIDTH = RESOLUTION + SYMBOL_WIDTH;
  localparam logic [ACC_WIDTH-1:0]    TOTAL    = ACC_WIDTH'(1) << RESOLUTION;
  localparam logic [SYMBOL_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_CHECK,
    S_ERR,
    S_ENC,
    S_DRAIN
  } state_t;

  state_t                  state;
  logic [SYMBOL_WIDTH-1:0] idx;
  logic [ACC_WIDTH-1:0]    acc;
  logic                    abort_pend;
  logic                    drain_first;

  // NOTE: sym_ready_o must follow enc_ready_i in the same cycle, so it is decoded
  // from the state register rather than registered like the other outputs.
  assign sym_ready_o = (state == S_ENC) & enc_ready_i & ~enc_en_o;

  // NOTE: all state and registered outputs use non-blocking assignments; where two
  // assignments to the same register fire in one cycle, the later one in this block wins.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state          <= S_IDLE;
      idx            <= '0;
      acc            <= '0;
      abort_pend     <= 1'b0;
      drain_first    <= 1'b0;
      enc_rst_o      <= 1'b1;
      tbl_ready_o    <= 1'b0;
      enc_en_o       <= 1'b0;
      enc_freq_wr_o  <= 1'b0;
      enc_freq_o     <= '0;
      enc_cum_freq_o <= '0;
      enc_symb_o     <= '0;
      out_valid_o    <= 1'b0;
      out_data_o     <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      byte_cnt_o     <= '0;
    end else begin
      enc_rst_o     <= 1'b0;
      tbl_ready_o   <= 1'b0;
      enc_en_o      <= 1'b0;
      enc_freq_wr_o <= 1'b0;
      done_o        <= 1'b0;

      // Output byte path runs in every state with one cycle of latency.
      out_valid_o <= enc_valid_i;
      out_data_o  <= enc_data_i;
      if (enc_valid_i && byte_cnt_o != '1) begin
        byte_cnt_o <= byte_cnt_o + CNT_WIDTH'(1);
      end

      if (abort_i && state != S_IDLE) begin
        state      <= S_CLR;
        abort_pend <= 1'b1;
        enc_rst_o  <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              state      <= S_CLR;
              busy_o     <= 1'b1;
              enc_rst_o  <= 1'b1;
              err_o      <= 1'b0;
              byte_cnt_o <= '0;
            end
          end

          S_CLR: begin
            idx         <= '0;
            acc         <= '0;
            drain_first <= 1'b0;
            if (abort_pend) begin
              abort_pend <= 1'b0;
              busy_o     <= 1'b0;
              state      <= S_IDLE;
            end else begin
              tbl_ready_o <= 1'b1;
              state       <= S_LOAD;
            end
          end

          S_LOAD: begin
            tbl_ready_o <= 1'b1;
            if (tbl_valid_i && tbl_ready_o) begin
              enc_freq_wr_o  <= 1'b1;
              enc_freq_o     <= tbl_freq_i;
              enc_cum_freq_o <= acc[RESOLUTION-1:0];
              enc_symb_o     <= idx;
              acc            <= acc + ACC_WIDTH'(tbl_freq_i);
              idx            <= idx + SYMBOL_WIDTH'(1);
              if (idx == LAST_IDX) begin
                tbl_ready_o <= 1'b0;
                state       <= S_CHECK;
              end
            end
          end

          S_CHECK: begin
            if (acc == TOTAL) begin
              state <= S_ENC;
            end else begin
              err_o     <= 1'b1;
              enc_rst_o <= 1'b1;
              state     <= S_ERR;
            end
          end

          S_ERR: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end

          S_ENC: begin
            if (sym_valid_i && sym_ready_o) begin
              enc_en_o   <= 1'b1;
              enc_symb_o <= sym_i;
              if (sym_last_i) begin
                drain_first <= 1'b1;
                state       <= S_DRAIN;
              end
            end
          end

          S_DRAIN: begin
            // The encoder status is not yet meaningful in the cycle after the last strobe.
            if (drain_first) begin
              drain_first <= 1'b0;
            end else if (enc_ready_i && !enc_valid_i) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end
          end

          default: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rans_enc_ctrl.sv
// Self-checking bench for rans_enc_ctrl: table-driven frames plus hand-written
// reset and abort sequences, with scoreboards for table writes, symbols and bytes.
module tb_rans_enc_ctrl;

  localparam int RES  = 10;
  localparam int SW   = 8;
  localparam int CW   = 32;
  localparam int NSYM = 256;

  logic          clk = 1'b0;
  logic          rst_i, start_i, abort_i;
  logic          tbl_valid_i;
  logic [RES-1:0] tbl_freq_i;
  logic          tbl_ready_o;
  logic          sym_valid_i;
  logic [SW-1:0] sym_i;
  logic          sym_last_i;
  logic          sym_ready_o;
  logic          enc_rst_o, enc_en_o, enc_freq_wr_o;
  logic [RES-1:0] enc_freq_o, enc_cum_freq_o;
  logic [SW-1:0] enc_symb_o;
  logic          enc_ready_i, enc_valid_i;
  logic [SW-1:0] enc_data_i;
  logic          out_valid_o;
  logic [SW-1:0] out_data_o;
  logic          busy_o, done_o, err_o;
  logic [CW-1:0] byte_cnt_o;

  always #5 clk = ~clk;

  rans_enc_ctrl #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .tbl_valid_i(tbl_valid_i), .tbl_freq_i(tbl_freq_i), .tbl_ready_o(tbl_ready_o),
    .sym_valid_i(sym_valid_i), .sym_i(sym_i), .sym_last_i(sym_last_i), .sym_ready_o(sym_ready_o),
    .enc_rst_o(enc_rst_o), .enc_en_o(enc_en_o), .enc_freq_wr_o(enc_freq_wr_o),
    .enc_freq_o(enc_freq_o), .enc_cum_freq_o(enc_cum_freq_o), .enc_symb_o(enc_symb_o),
    .enc_ready_i(enc_ready_i), .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .byte_cnt_o(byte_cnt_o)
  );

  typedef struct {
    int base;      // frequency of entries 1..NSYM-2
    int first;     // frequency of entry 0
    int last;      // frequency of entry NSYM-1
    int nsyms;
    int nbytes;
    bit exp_err;
    int exp_cum5;
  } frame_t;

  typedef struct {
    logic [RES-1:0] freq;
    logic [RES-1:0] cum;
    logic [SW-1:0]  idx;
  } wr_t;

  frame_t        rows[6];
  wr_t           wr_q[$];
  wr_t           wr_exp;
  logic [SW-1:0] sym_q[$];
  logic [SW-1:0] byte_q[$];
  logic [SW-1:0] exp_byte;

  int checks = 0;
  int errors = 0;
  int wr_cnt, en_cnt, rst_cnt, done_cnt, viol, symrdy_seen, cum5;
  logic prev_ready = 1'b0;
  logic prev_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    wr_cnt = 0; en_cnt = 0; rst_cnt = 0; done_cnt = 0;
    viol = 0; symrdy_seen = 0; cum5 = -1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_i && !abort_i && sym_valid_i && sym_ready_o) sym_q.push_back(sym_i);
    if (enc_freq_wr_o) begin
      wr_cnt++;
      if (enc_symb_o == 8'd5) cum5 = int'(enc_cum_freq_o);
      check("wr_expected", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) begin
        wr_exp = wr_q.pop_front();
        check("wr_freq", enc_freq_o, wr_exp.freq);
        check("wr_cum", enc_cum_freq_o, wr_exp.cum);
        check("wr_idx", enc_symb_o, wr_exp.idx);
      end
    end
    if (enc_en_o) begin
      en_cnt++;
      if (!prev_ready || prev_en) viol++;
      check("en_expected", sym_q.size() > 0, 1);
      if (sym_q.size() > 0) check("en_symbol", enc_symb_o, sym_q.pop_front());
    end
    if (out_valid_o) begin
      check("byte_expected", byte_q.size() > 0, 1);
      if (byte_q.size() > 0) begin
        exp_byte = byte_q.pop_front();
        check("out_byte", out_data_o, exp_byte);
      end
    end
    if (sym_ready_o && !enc_ready_i) viol++;
    if (sym_ready_o) symrdy_seen++;
    if (enc_rst_o) rst_cnt++;
    if (done_o) done_cnt++;
    prev_ready = enc_ready_i;
    prev_en    = enc_en_o;
  end

  task automatic check_reset_state(input string name);
    check({name, "_ctrl"},
          {enc_rst_o, busy_o, tbl_ready_o, sym_ready_o, enc_freq_wr_o, enc_en_o, done_o, err_o, out_valid_o},
          9'b1_0000_0000);
    check({name, "_byte_cnt"}, byte_cnt_o, 0);
    check({name, "_symb"}, enc_symb_o, 0);
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_enc_rst", enc_rst_o, 1);
    check("start_err_clr", err_o, 0);
    check("start_cnt_clr", byte_cnt_o, 0);
  endtask

  // Drives n table entries; the expected cumulative frequency is kept here.
  task automatic load_table(input int n, input int base, input int first, input int last);
    int cum = 0;
    int f;
    int guard;
    for (int i = 0; i < n; i++) begin
      f = (i == 0) ? first : ((i == NSYM - 1) ? last : base);
      tbl_valid_i = 1'b1;
      tbl_freq_i  = RES'(f);
      guard = 0;
      @(negedge clk);
      while (!tbl_ready_o && guard < 20) begin
        @(posedge clk); #1;
        @(negedge clk);
        guard++;
      end
      if (!tbl_ready_o) begin
        check("tbl_ready_timeout", tbl_ready_o, 1);
        tbl_valid_i = 1'b0;
        return;
      end
      wr_q.push_back('{freq: RES'(f), cum: RES'(cum), idx: SW'(i)});
      cum += f;
      step();
      if (i < n - 1 && $urandom_range(0, 7) == 0) begin
        tbl_valid_i = 1'b0;
        step();
      end
    end
    tbl_valid_i = 1'b0;
  endtask

  // Encoder readiness toggles 1/0 every three cycles while symbols are offered.
  task automatic send_syms(input int n, input bit with_last);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 2000) begin
      enc_ready_i = ((cyc / 3) % 2) == 0;
      sym_valid_i = 1'b1;
      sym_i       = SW'(32'h41 + k);
      sym_last_i  = with_last && (k == n - 1);
      @(negedge clk);
      if (sym_ready_o) k++;
      step();
      cyc++;
    end
    sym_valid_i = 1'b0;
    sym_last_i  = 1'b0;
    check("sym_stream_complete", k, n);
  endtask

  task automatic drain(input int nbytes);
    enc_ready_i = 1'b0;
    for (int j = 0; j < nbytes; j++) begin
      enc_valid_i = 1'b1;
      enc_data_i  = SW'($urandom);
      enc_ready_i = (j == nbytes - 1);
      byte_q.push_back(enc_data_i);
      step();
      check("drain_hold", {done_o, busy_o}, 2'b01);
    end
    enc_valid_i = 1'b0;
    enc_ready_i = 1'b1;
    for (int t = 0; t < 20 && done_cnt == 0; t++) step();
    check("done_seen", done_cnt, 1);
    step();
    step();
    check("done_idle", busy_o, 0);
  endtask

  task automatic run_frame(input frame_t f);
    clear_counters();
    enc_ready_i = 1'b1;
    start_frame();
    step();
    check("load_ready", tbl_ready_o, 1);
    load_table(NSYM, f.base, f.first, f.last);
    step();
    check("err_after_check", err_o, f.exp_err);
    if (f.exp_err) begin
      check("err_enc_rst", enc_rst_o, 1);
      step();
      check("err_idle", busy_o, 0);
      check("err_sticky", err_o, 1);
      repeat (3) step();
      check("err_no_sym_ready", symrdy_seen, 0);
      check("err_enc_rst_cycles", rst_cnt, 2);
    end else begin
      send_syms(f.nsyms, 1'b1);
      drain(f.nbytes);
      check("byte_cnt", byte_cnt_o, f.nbytes);
      check("enc_rst_cycles", rst_cnt, 1);
    end
    check("freq_wr_cnt", wr_cnt, NSYM);
    check("cum5", cum5, f.exp_cum5);
    check("enc_en_cnt", en_cnt, f.exp_err ? 0 : f.nsyms);
    check("done_cnt", done_cnt, f.exp_err ? 0 : 1);
    check("flow_violations", viol, 0);
    check("queues_empty", wr_q.size() + sym_q.size() + byte_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          base first last nsyms nbytes err cum5
    rows[0] = '{4,   4,    4,    16,   7,     0,  20};
    rows[1] = '{3,   3,    3,    0,    0,     1,  15};
    rows[2] = '{4,   5,    4,    0,    0,     1,  21};
    rows[3] = '{1,   769,  1,    5,    0,     0,  773};
    rows[4] = '{0,   0,    1023, 0,    0,     1,  0};
    rows[5] = '{0,   1,    1023, 1,    3,     0,  1};

    rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    tbl_valid_i = 1'b0; tbl_freq_i = '0;
    sym_valid_i = 1'b0; sym_i = '0; sym_last_i = 1'b0;
    enc_ready_i = 1'b0; enc_valid_i = 1'b0; enc_data_i = '0;
    clear_counters();

    repeat (3) step();
    check_reset_state("por");
    rst_i = 1'b1;
    step();
    check("por_release_enc_rst", enc_rst_o, 0);

    for (int r = 0; r < 6; r++) run_frame(rows[r]);

    // start ignored while encoding, then abort from ENC
    clear_counters();
    enc_ready_i = 1'b1;
    start_frame();
    step();
    load_table(NSYM, 4, 4, 4);
    step();
    check("abort_frame_err", err_o, 0);
    send_syms(4, 1'b0);
    enc_ready_i = 1'b0;
    step();
    for (int j = 0; j < 2; j++) begin
      enc_valid_i = 1'b1;
      enc_data_i  = SW'(8'hC0 + j);
      byte_q.push_back(enc_data_i);
      step();
    end
    enc_valid_i = 1'b0;
    step();
    check("enc_bytes", byte_cnt_o, 2);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("busy_start_busy", busy_o, 1);
    check("busy_start_no_rst", enc_rst_o, 0);
    check("busy_start_cnt_kept", byte_cnt_o, 2);
    enc_ready_i = 1'b1;
    #1;
    check("still_encoding", sym_ready_o, 1);
    enc_ready_i = 1'b0;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_enc_rst", enc_rst_o, 1);
    check("abort_busy", busy_o, 1);
    step();
    check("abort_rst_end", enc_rst_o, 0);
    check("abort_idle", busy_o, 0);
    check("abort_cnt_held", byte_cnt_o, 2);
    check("abort_no_done", done_cnt, 0);
    check("abort_en_cnt", en_cnt, 4);
    check("abort_tbl_ready", tbl_ready_o, 0);
    check("abort_queues", sym_q.size() + byte_q.size(), 0);

    // reset in the middle of LOAD at index 100, then a full frame from index 0
    clear_counters();
    enc_ready_i = 1'b0;
    start_frame();
    for (int j = 0; j < 3; j++) begin
      enc_valid_i = 1'b1;
      enc_data_i  = SW'(8'h30 + j);
      byte_q.push_back(enc_data_i);
      step();
    end
    enc_valid_i = 1'b0;
    step();
    check("load_bytes", byte_cnt_o, 3);
    load_table(100, 4, 4, 4);
    rst_i = 1'b0;
    step();
    check_reset_state("mid_load");
    check("partial_wr", wr_cnt, 100);
    rst_i = 1'b1;
    step();
    check("mid_load_release", {enc_rst_o, busy_o}, 2'b00);
    check("mid_load_wr_q", wr_q.size(), 0);
    run_frame(rows[0]);

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
